// File: rtl/stream_acc_pkg.sv
// Shared types and constants for the stream accumulator block.
// STREAM_ACC_SATURATE_EN selects saturating accumulation in stream_accumulator_32.
package stream_acc_pkg;

   localparam int unsigned DefaultN    = 32;
   localparam int unsigned DefaultLenW = 8;

   localparam logic [DefaultN-1:0] ACC_ALL_ONES = '1;

   typedef enum logic [1:0] {
      StIdle,
      StAccum,
      StDone
   } acc_state_e;

endpackage

// File: rtl/acc_adder_n.sv
// Combinational N-bit ripple-carry adder with carry-out from the MSB.
module acc_adder_n #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         carry_out
);

   logic carry;

   // Single-bit carry variable threaded through the loop keeps the chain acyclic.
   always_comb begin
      carry = 1'b0;
      sum   = '0;
      for (int i = 0; i < int'(N); i++) begin
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      carry_out = carry;
   end

endmodule

// File: rtl/stream_accumulator_32.sv
// Burst accumulator: sums len operands over a valid/ready stream and presents sum + sticky carry.
// Define STREAM_ACC_SATURATE_EN to clamp the accumulator to all-ones on the first carry.
module stream_accumulator_32
   import stream_acc_pkg::*;
#(
   parameter int unsigned N     = DefaultN,
   parameter int unsigned LEN_W = DefaultLenW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_carry,
   output logic             busy
);

   acc_state_e       state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     add_sum;
   logic             add_carry;

   acc_adder_n #(
      .N (N)
   ) u_adder (
      .a         (acc_q),
      .b         (in_data),
      .sum       (add_sum),
      .carry_out (add_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = len;
               state_d = (len == '0) ? StDone : StAccum;
            end
         end
         StAccum: begin
            if (in_valid && in_ready) begin
`ifdef STREAM_ACC_SATURATE_EN
               acc_d = (ovf_q || add_carry) ? N'(ACC_ALL_ONES) : add_sum;
`else
               acc_d = add_sum;
`endif
               ovf_d = ovf_q | add_carry;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decode only registered state, so no input reaches an output combinationally.
   always_comb begin
      in_ready  = (state_q == StAccum);
      out_valid = (state_q == StDone);
      busy      = (state_q != StIdle);
      out_sum   = (state_q == StDone) ? acc_q : '0;
      out_carry = (state_q == StDone) ? ovf_q : 1'b0;
   end

endmodule

// File: tb/tb_stream_accumulator_32.sv
// Directed self-checking bench for stream_accumulator_32 (wrap or saturate build).
module tb_stream_accumulator_32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_sum;
   logic        out_carry;
   logic        busy;

   int checks = 0;
   int failures = 0;

   stream_accumulator_32 dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_carry (out_carry),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_sum !== 32'h0) begin failures++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
      checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [31:0] ops [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
      out_ready = 1'b1;
      start = 1'b1;
      len = 8'd4;
      tick();
      start = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid op=%0d got=%b exp=0", i, out_valid); end
         in_valid = 1'b1;
         in_data = ops[i];
         tick();
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_sum !== 32'd10) begin failures++; $display("FAIL basic_sum got=%h exp=a", out_sum); end
      checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL basic_carry got=%b exp=0", out_carry); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_sum;
`ifdef STREAM_ACC_SATURATE_EN
      exp_sum = 32'hFFFF_FFFF;
`else
      exp_sum = 32'h0000_0001;
`endif
      start = 1'b1;
      len = 8'd2;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 32'hFFFF_FFFF;
      tick();
      in_data = 32'h0000_0002;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ovf_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_sum !== exp_sum) begin failures++; $display("FAIL ovf_sum got=%h exp=%h", out_sum, exp_sum); end
      checks++; if (out_carry !== 1'b1) begin failures++; $display("FAIL ovf_carry got=%b exp=1", out_carry); end
      tick();
   endtask

   task automatic test_empty();
      start = 1'b1;
      len = 8'd0;
      tick();
      start = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL empty_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_sum !== 32'h0) begin failures++; $display("FAIL empty_sum got=%h exp=0", out_sum); end
      checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL empty_carry got=%b exp=0", out_carry); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL empty_in_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL empty_in_ready_after got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_done got=%b exp=0", out_valid); end
   endtask

   task automatic test_gaps();
      logic        vld [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] dat [5] = '{32'd5, 32'hDEAD, 32'hBEEF, 32'd6, 32'd7};
      out_ready = 1'b0;
      start = 1'b1;
      len = 8'd3;
      tick();
      for (int i = 0; i < 5; i++) begin
         // start pulses mid-burst must be ignored
         start = (i == 1 || i == 3);
         len = 8'd9;
         in_valid = vld[i];
         in_data = dat[i];
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL gaps_in_ready step=%0d got=%b exp=1", i, in_ready); end
         tick();
      end
      in_valid = 1'b0;
      start = 1'b1;
      len = 8'd0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL gaps_hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
         checks++; if (out_sum !== 32'd18) begin failures++; $display("FAIL gaps_hold_sum cyc=%0d got=%h exp=12", i, out_sum); end
         tick();
      end
      // accept while start is high: start must not be taken this cycle
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gaps_start_in_done got=%b exp=0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL gaps_released got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      start = 1'b1;
      len = 8'd5;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 32'd10;
      tick();
      in_data = 32'd20;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=0", in_ready); end
      tick();
      rst = 1'b0;
      tick();
      start = 1'b1;
      len = 8'd1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 32'd7;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fresh_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_sum !== 32'd7) begin failures++; $display("FAIL fresh_sum got=%h exp=7", out_sum); end
      checks++; if (out_carry !== 1'b0) begin failures++; $display("FAIL fresh_carry got=%b exp=0", out_carry); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_empty();
      test_gaps();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
